// File: rtl/jvm_pkg.sv
// Shared JVM bytecode decode definitions: widths, opcode constants, decoder states
// and the operand-length classification.
package jvm_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned OPND_W = 16;

    typedef enum logic [2:0] {
        S_OPC = 3'd0,
        S_OP1 = 3'd1,
        S_OP2 = 3'd2,
        S_OUT = 3'd3,
        S_ERR = 3'd4
    } dec_state_e;

    // Operand byte count per opcode; LEN_ILL marks opcodes this decoder rejects.
    typedef enum logic [1:0] {
        LEN_0   = 2'd0,
        LEN_1   = 2'd1,
        LEN_2   = 2'd2,
        LEN_ILL = 2'd3
    } op_len_e;

    localparam logic [BYTE_W-1:0] OP_BIPUSH  = 8'h10;
    localparam logic [BYTE_W-1:0] OP_SIPUSH  = 8'h11;
    localparam logic [BYTE_W-1:0] OP_LDC     = 8'h12;
    localparam logic [BYTE_W-1:0] OP_ILOAD   = 8'h15;
    localparam logic [BYTE_W-1:0] OP_ISTORE  = 8'h36;
    localparam logic [BYTE_W-1:0] OP_IINC    = 8'h84;
    localparam logic [BYTE_W-1:0] OP_IFEQ    = 8'h99;
    localparam logic [BYTE_W-1:0] OP_GOTO    = 8'hA7;
    localparam logic [BYTE_W-1:0] OP_TABLESW = 8'hAA;
    localparam logic [BYTE_W-1:0] OP_LOOKUSW = 8'hAB;
    localparam logic [BYTE_W-1:0] OP_INVDYN  = 8'hBA;
    localparam logic [BYTE_W-1:0] OP_WIDE    = 8'hC4;
    localparam logic [BYTE_W-1:0] OP_ILL_LO  = 8'hCA;

endpackage

// File: rtl/opcode_len_lut.sv
// Combinational opcode classifier: operand byte count or illegal.
module opcode_len_lut
    import jvm_pkg::*;
(
    input  logic [BYTE_W-1:0] opcode,
    output op_len_e           op_len
);

    always_comb begin
        op_len = LEN_0;
        case (opcode)
            OP_BIPUSH, OP_LDC, OP_ILOAD, OP_ISTORE:        op_len = LEN_1;
            OP_SIPUSH, OP_IINC:                            op_len = LEN_2;
            OP_TABLESW, OP_LOOKUSW, OP_INVDYN, OP_WIDE:    op_len = LEN_ILL;
            default: begin
                if (opcode >= OP_ILL_LO) begin
                    op_len = LEN_ILL;
                end else if (opcode >= OP_IFEQ && opcode <= OP_GOTO) begin
                    op_len = LEN_2;
                end
            end
        endcase
    end

endmodule

// File: rtl/bytecode_decoder.sv
// Assembles JVM bytecode bytes into opcode + big-endian operand instructions,
// holding each until the consumer accepts it.
module bytecode_decoder
    import jvm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_ready,
    output logic              byte_req,
    input  logic              flush,
    output logic              insn_valid,
    input  logic              insn_accept,
    output logic [BYTE_W-1:0] insn_opcode,
    output logic [OPND_W-1:0] insn_operand,
    output logic [1:0]        insn_len,
    output logic              illegal
);

    dec_state_e        state;
    op_len_e           lut_len;
    logic [BYTE_W-1:0] op_hi;
    logic              consume;

    opcode_len_lut u_len_lut (
        .opcode (byte_in),
        .op_len (lut_len)
    );

    // Byte request depends on state only, so it never combinationally follows inputs.
    assign byte_req = (state == S_OPC) || (state == S_OP1) || (state == S_OP2);
    assign consume  = byte_req && byte_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_OPC;
            insn_valid   <= 1'b0;
            illegal      <= 1'b0;
            insn_opcode  <= '0;
            insn_operand <= '0;
            insn_len     <= 2'd0;
            op_hi        <= '0;
        end else if (flush && state != S_ERR) begin
            // Redirect: drop whatever was partially assembled or held.
            state        <= S_OPC;
            insn_valid   <= 1'b0;
            insn_opcode  <= '0;
            insn_operand <= '0;
            insn_len     <= 2'd0;
            op_hi        <= '0;
        end else begin
            case (state)
                S_OPC: begin
                    if (consume) begin
                        insn_opcode  <= byte_in;
                        insn_operand <= '0;
                        op_hi        <= '0;
                        case (lut_len)
                            LEN_ILL: begin
                                state    <= S_ERR;
                                illegal  <= 1'b1;
                                insn_len <= 2'd0;
                            end
                            LEN_0: begin
                                state      <= S_OUT;
                                insn_valid <= 1'b1;
                                insn_len   <= 2'd0;
                            end
                            default: begin
                                state    <= S_OP1;
                                insn_len <= 2'(lut_len);
                            end
                        endcase
                    end
                end
                S_OP1: begin
                    if (consume) begin
                        if (insn_len == 2'd1) begin
                            insn_operand <= {8'h00, byte_in};
                            insn_valid   <= 1'b1;
                            state        <= S_OUT;
                        end else begin
                            op_hi <= byte_in;
                            state <= S_OP2;
                        end
                    end
                end
                S_OP2: begin
                    if (consume) begin
                        insn_operand <= {op_hi, byte_in};
                        insn_valid   <= 1'b1;
                        state        <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (insn_accept) begin
                        insn_valid <= 1'b0;
                        state      <= S_OPC;
                    end
                end
                S_ERR: begin
                    // Sticky until reset.
                    illegal    <= 1'b1;
                    insn_valid <= 1'b0;
                end
                default: begin
                    state <= S_OPC;
                end
            endcase
        end
    end

endmodule

// File: doc/bytecode_decoder.md
BYTECODE_DECODER -- requirements
Module: bytecode_decoder

Interface
REQ-001 SHALL have no parameters; byte width 8 and operand width 16 are fixed.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: byte_in  in  8  bytecode byte from the upstream byte fetcher.
REQ-005 SHALL have port: byte_ready  in  1  byte_in valid this cycle.
REQ-006 SHALL have port: byte_req  out  1  decoder wants a byte; drives fetcher start.
REQ-007 SHALL have port: flush  in  1  discard partial or held instruction (branch redirect).
REQ-008 SHALL have port: insn_valid  out  1  assembled instruction available.
REQ-009 SHALL have port: insn_accept  in  1  consumer takes the instruction.
REQ-010 SHALL have port: insn_opcode  out  8  opcode byte.
REQ-011 SHALL have port: insn_operand  out  16  operand bytes, big-endian, zero-extended.
REQ-012 SHALL have port: insn_len  out  2  operand byte count, 0..2.
REQ-013 SHALL have port: illegal  out  1  unsupported opcode seen; sticky.

Function
REQ-014 SHALL treat a byte as consumed only in a cycle where byte_req and byte_ready are both 1.
REQ-015 SHALL implement states S_OPC, S_OP1, S_OP2, S_OUT, S_ERR.
REQ-016 SHALL assert byte_req only in S_OPC, S_OP1 and S_OP2.
REQ-017 SHALL, in S_OPC on consume, latch the opcode and clear insn_operand.
REQ-018 SHALL, in S_OPC on consume, go to S_OUT if len=0, S_OP1 if len>=1, or S_ERR if the opcode is unsupported.
REQ-019 SHALL use this length table:
- len 1: bipush 0x10, ldc 0x12, iload 0x15, istore 0x36.
- len 2: sipush 0x11, iinc 0x84, 0x99-0xA7 (if*, goto).
- illegal: 0xAA, 0xAB, 0xBA, 0xC4, 0xCA-0xFF.
- len 0: all other opcodes.
REQ-020 SHALL, in S_OP1 on consume: if len=1, set operand={8'h00,byte} and go to S_OUT; else latch the high byte and go to S_OP2.
REQ-021 SHALL, in S_OP2 on consume, set operand={high,byte} and go to S_OUT.
REQ-022 SHALL, in S_OUT, hold insn_valid=1 with stable opcode, operand and len until insn_accept.
REQ-023 SHALL, on insn_accept in S_OUT, go to S_OPC, giving a minimum of 1 bubble cycle between instructions.
REQ-024 SHALL stay in the current state while byte_req=1 and byte_ready=0, with no change to outputs.
REQ-025 SHALL ignore insn_accept when insn_valid=0.
REQ-026 SHALL ignore byte_ready when byte_req=0.
REQ-027 SHALL, on flush in any state except S_ERR, go to S_OPC next cycle and drop partial or held data.
REQ-028 SHALL give flush priority over insn_accept and over a same-cycle byte consume.
REQ-029 SHALL, in S_ERR, drive illegal=1, insn_valid=0, byte_req=0, and leave S_ERR only on reset; flush has no effect in S_ERR.
REQ-030 SHALL give one-instruction latency: insn_valid rises the cycle after the final byte is consumed.

Reset
REQ-031 SHALL, on reset, set state=S_OPC, insn_valid=0, illegal=0, insn_opcode=0, insn_operand=0, insn_len=0.
REQ-032 SHALL give reset priority over flush and all handshakes.
REQ-033 SHALL, on reset mid-instruction, discard partial data; byte_req=1 the cycle after reset deasserts.

Structure
REQ-034 SHALL take opcode constants, the state enum and the length/illegal encoding from shared package jvm_pkg.
REQ-035 SHALL place opcode-to-length/illegal classification in combinational sub-module opcode_len_lut.
REQ-036 SHALL register every output; no combinational path from any input to any output except byte_req, which is state-only.

Verification
REQ-037 SHALL cover: bytes 0x60 (iadd) -> insn_valid, opcode=0x60, len=0, operand=0x0000.
REQ-038 SHALL cover: bytes 0x11,0x12,0x34 with byte_ready gaps -> opcode=0x11, operand=0x1234, len=2.
REQ-039 SHALL cover: insn_accept held low 5 cycles -> outputs stable, byte_req=0 throughout.
REQ-040 SHALL cover: 0xA7,0xFF then flush before the second operand byte -> no insn_valid; next byte 0x03 decoded as opcode.
REQ-041 SHALL cover: byte 0xAA -> illegal=1, byte_req=0; flush has no effect; reset clears illegal.
REQ-042 SHALL cover: reset asserted in S_OP1 of bipush -> outputs at reset values; next byte decoded as a fresh opcode.
